ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, giving the RAM address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving the RAM data width.
REQ-003 SHALL have port clk, input, 1: the single clock for all state.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port booting, input, 1: when high, the CPU is locked out of new grants.
REQ-006 SHALL have port boot_req, input, 1: the bootloader requests a write.
REQ-007 SHALL have port boot_addr, input, ADDR_BITS: the bootloader write address.
REQ-008 SHALL have port boot_wdata, input, DATA_BITS: the bootloader write data.
REQ-009 SHALL have port boot_gnt, output, 1: one-cycle pulse marking the bootloader write as issued.
REQ-010 SHALL have port cpu_req, input, 1: the CPU requests an access.
REQ-011 SHALL have port cpu_we, input, 1: 1 selects write, 0 selects read.
REQ-012 SHALL have port cpu_addr, input, ADDR_BITS: the CPU access address.
REQ-013 SHALL have port cpu_wdata, input, DATA_BITS: the CPU write data.
REQ-014 SHALL have port cpu_gnt, output, 1: one-cycle pulse marking the CPU access as issued.
REQ-015 SHALL have port cpu_rdata, output, DATA_BITS: read data, valid while cpu_rvalid is high.
REQ-016 SHALL have port cpu_rvalid, output, 1: one-cycle read-data strobe.
REQ-017 SHALL have port ram_addr, output, ADDR_BITS: address to the RAM port.
REQ-018 SHALL have port ram_we, output, 1: write enable to the RAM port.
REQ-019 SHALL have port ram_di, output, DATA_BITS: write data to the RAM.
REQ-020 SHALL have port ram_do, input, DATA_BITS: RAM read data, one clk after the address.
REQ-021 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-022 SHALL implement the FSM states IDLE, ISSUE and RD_WAIT.
REQ-023 In IDLE with at least one eligible request at edge N, the FSM SHALL select a winner, latch the winner's addr/wdata/we, and enter ISSUE.
- An eligible request is boot_req, or cpu_req while booting is 0.
REQ-024 In ISSUE (cycle N+1), the block SHALL drive ram_addr/ram_di/ram_we from the latched values.
- It SHALL pulse the winner's gnt for exactly one cycle.
REQ-025 A requester SHALL hold req and its operands stable until its gnt; the arbiter SHALL sample operands only at the arbitration edge.
REQ-026 ISSUE SHALL go to IDLE for writes and to RD_WAIT for CPU reads.
REQ-027 In RD_WAIT (N+2), cpu_rdata SHALL equal ram_do, cpu_rvalid SHALL be 1, and the next state SHALL be IDLE.
REQ-028 Throughput SHALL be one write per 2 cycles and one read per 3 cycles; IDLE SHALL always be visited for one cycle between accesses.
REQ-029 ram_we SHALL be 0 in every state except ISSUE-with-write; ram_addr and ram_di SHALL hold their last values outside ISSUE.
REQ-030 A rise of booting during ISSUE or RD_WAIT SHALL NOT abort the CPU access in progress; the lockout SHALL apply from the next arbitration.
REQ-031 Address and data SHALL pass through unmodified at full width; no wrap or offset SHALL be applied.
REQ-032 A boot_req from the bootloader SHALL never be issued as a read, regardless of any other input.

Reset
REQ-033 While rst is 0, the block SHALL be in state IDLE.
- All outputs SHALL be 0: boot_gnt, cpu_gnt, cpu_rvalid, cpu_rdata, ram_addr, ram_we, ram_di, busy.
- The last-winner register SHALL be CPU.
REQ-034 Reset asserted during ISSUE or RD_WAIT SHALL drop the access; no gnt or rvalid SHALL follow the release of reset.

Configuration
REQ-035 With macro ARB_ROUND_ROBIN_EN defined, simultaneous eligible requests SHALL go to the requester that did not win the last granted access.
- The last-winner register updates on each grant.
REQ-036 Without ARB_ROUND_ROBIN_EN, boot_req SHALL always win contention (fixed priority), and the last-winner register SHALL be absent.

Verification
REQ-037 CPU write, addr 0x0012 data 0xA5 -> ram_we=1, ram_addr=0x0012, ram_di=0xA5 and cpu_gnt=1 on cycle N+1; busy low at N+2.
REQ-038 CPU read, addr 0x0034, RAM holding 0x5C -> cpu_gnt at N+1, cpu_rvalid=1 with cpu_rdata=0x5C at N+2, IDLE at N+3.
REQ-039 booting=1, cpu_req and boot_req both held for 6 cycles -> three boot_gnt pulses, zero cpu_gnt pulses.
REQ-040 booting=0, both requesting continuously with the macro defined -> grants alternate boot, cpu, boot, cpu; without the macro -> boot only.
REQ-041 rst driven low in RD_WAIT, released after 2 cycles -> all outputs 0, no cpu_rvalid pulse; the next cpu_req is serviced normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter (bootloader writes, CPU reads/writes) onto one synchronous RAM port.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed boot priority.
module ram_arbiter #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 booting,
    input  logic                 boot_req,
    input  logic [ADDR_BITS-1:0] boot_addr,
    input  logic [DATA_BITS-1:0] boot_wdata,
    output logic                 boot_gnt,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [DATA_BITS-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic [DATA_BITS-1:0] cpu_rdata,
    output logic                 cpu_rvalid,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_we,
    output logic [DATA_BITS-1:0] ram_di,
    input  logic [DATA_BITS-1:0] ram_do,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t state;
    logic   boot_elig;
    logic   cpu_elig;
    logic   pick_boot;

    assign boot_elig = boot_req;
    assign cpu_elig  = cpu_req & ~booting;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_boot;
    // Under contention the requester that did not win last time goes next.
    assign pick_boot = boot_elig & (~cpu_elig | ~last_boot);
`else
    assign pick_boot = boot_elig;
`endif

    // RAM returns data one clock after the address, i.e. exactly in RD_WAIT.
    assign cpu_rdata = cpu_rvalid ? ram_do : '0;

    // Arbitration FSM with registered RAM-side and grant outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            boot_gnt   <= 1'b0;
            cpu_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_di     <= '0;
            busy       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_boot  <= 1'b0;
`endif
        end else begin
            boot_gnt   <= 1'b0;
            cpu_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ram_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (boot_elig || cpu_elig) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        if (pick_boot) begin
                            ram_addr <= boot_addr;
                            ram_di   <= boot_wdata;
                            ram_we   <= 1'b1;
                            boot_gnt <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                            last_boot <= 1'b1;
`endif
                        end else begin
                            ram_addr <= cpu_addr;
                            ram_di   <= cpu_wdata;
                            ram_we   <= cpu_we;
                            cpu_gnt  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                            last_boot <= 1'b0;
`endif
                        end
                    end
                end
                ISSUE: begin
                    // Only a CPU access can be a read, so !ram_we means CPU read.
                    if (ram_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state      <= RD_WAIT;
                        cpu_rvalid <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small synchronous RAM model.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        booting;
    logic        boot_req;
    logic [15:0] boot_addr;
    logic [7:0]  boot_wdata;
    logic        boot_gnt;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;
    logic        busy;

    logic [7:0]  mem [0:255];
    int          n_checks;
    int          n_fails;
    int          n_boot;
    int          n_cpu;
    logic [3:0]  seq;
    int          seq_n;

    ram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .booting    (booting),
        .boot_req   (boot_req),
        .boot_addr  (boot_addr),
        .boot_wdata (boot_wdata),
        .boot_gnt   (boot_gnt),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_di     (ram_di),
        .ram_do     (ram_do),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one clock after the address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_di;
        ram_do <= mem[ram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_boot_gnt"}, 32'(boot_gnt), 32'd0);
        check({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'd0);
        check({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
        check({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_di"}, 32'(ram_di), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h34] = 8'h5C;
        ram_do     = 8'h00;
        rst        = 1'b0;
        booting    = 1'b0;
        boot_req   = 1'b0;
        boot_addr  = 16'h0000;
        boot_wdata = 8'h00;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_wdata  = 8'h00;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0012; cpu_wdata = 8'hA5;
        step();
        check("wr_gnt", 32'(cpu_gnt), 32'd1);
        check("wr_we", 32'(ram_we), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'h0012);
        check("wr_di", 32'(ram_di), 32'hA5);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_bgnt", 32'(boot_gnt), 32'd0);
        cpu_req = 1'b0;
        step();
        check("wr_n2_busy", 32'(busy), 32'd0);
        check("wr_n2_gnt", 32'(cpu_gnt), 32'd0);
        check("wr_n2_we", 32'(ram_we), 32'd0);
        check("wr_n2_addr_hold", 32'(ram_addr), 32'h0012);
        check("wr_mem", 32'(mem[8'h12]), 32'hA5);

        // CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0034;
        step();
        check("rd_gnt", 32'(cpu_gnt), 32'd1);
        check("rd_we", 32'(ram_we), 32'd0);
        check("rd_addr", 32'(ram_addr), 32'h0034);
        cpu_req = 1'b0;
        step();
        check("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_rdata", 32'(cpu_rdata), 32'h5C);
        check("rd_n2_gnt", 32'(cpu_gnt), 32'd0);
        check("rd_n2_busy", 32'(busy), 32'd1);
        step();
        check("rd_n3_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rd_n3_busy", 32'(busy), 32'd0);

        // booting rising mid-read does not abort the read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0012;
        step();
        check("lk_gnt", 32'(cpu_gnt), 32'd1);
        cpu_req = 1'b0; booting = 1'b1;
        step();
        check("lk_rvalid", 32'(cpu_rvalid), 32'd1);
        check("lk_rdata", 32'(cpu_rdata), 32'hA5);
        step();

        // Lockout: 6 cycles of contention while booting
        boot_req = 1'b1; boot_addr = 16'h0040; boot_wdata = 8'h11;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
        n_boot = 0; n_cpu = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (boot_gnt) begin
                n_boot++;
                check("boot_is_write", 32'(ram_we), 32'd1);
            end
            if (cpu_gnt) n_cpu++;
        end
        check("lock_boot_cnt", 32'(n_boot), 32'd3);
        check("lock_cpu_cnt", 32'(n_cpu), 32'd0);
        check("lock_mem", 32'(mem[8'h40]), 32'h11);
        boot_req = 1'b0; cpu_req = 1'b0; booting = 1'b0;
        step();

        // Contention with booting low, starting from reset (last winner = CPU)
        rst = 1'b0;
        step();
        rst = 1'b1;
        boot_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
        seq = 4'b0000; seq_n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if ((boot_gnt || cpu_gnt) && seq_n < 4) begin
                seq[seq_n] = boot_gnt;
                seq_n++;
            end
        end
        check("cont_grants", 32'(seq_n), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
        check("cont_order", 32'(seq), 32'b0101);
`else
        check("cont_order", 32'(seq), 32'b1111);
`endif
        boot_req = 1'b0; cpu_req = 1'b0;
        step();
        step();

        // Reset during RD_WAIT drops the read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0034;
        step();
        cpu_req = 1'b0;
        step();
        check("rst_pre_rvalid", 32'(cpu_rvalid), 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("rst_rdwait");
        step();
        step();
        check("rst_hold_rvalid", 32'(cpu_rvalid), 32'd0);
        rst = 1'b1;
        step();
        check("rst_rel_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_rel_gnt", 32'(cpu_gnt), 32'd0);
        check("rst_rel_busy", 32'(busy), 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0034;
        step();
        check("post_gnt", 32'(cpu_gnt), 32'd1);
        cpu_req = 1'b0;
        step();
        check("post_rvalid", 32'(cpu_rvalid), 32'd1);
        check("post_rdata", 32'(cpu_rdata), 32'h5C);
        step();
        check("post_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
